// File: rtl/uart_echo_buffer.sv
// rtl/uart_echo_buffer.sv - byte FIFO between a UART receiver and transmitter
// Optional upper-case folding of TxData when UART_ECHO_CASE_FOLD_EN is defined.
module uart_echo_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [WIDTH-1:0]           RxData,
  input  logic                       RxValid,
  output logic                       RxReady,
  output logic [WIDTH-1:0]           TxData,
  output logic                       TxValid,
  input  logic                       TxReady,
  input  logic                       Flush,
  output logic [$clog2(DEPTH):0]     Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rdy_q;
  logic             push, pop;
  logic [WIDTH-1:0] tx_raw;

  // rdy_q keeps RxReady low while Reset is held and releases it on the first edge after.
  assign RxReady = rdy_q && (cnt_q != CW'(DEPTH)) && !Flush;
  assign TxValid = (cnt_q != '0);
  assign Count   = cnt_q;

  assign push = RxValid && RxReady;
  assign pop  = TxValid && TxReady && !Flush;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (Flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      rdy_q <= 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (push) mem_q[wr_q] <= RxData;
  end

  // Gating on occupancy forces TxData to zero while empty or in reset.
  assign tx_raw = TxValid ? mem_q[rd_q] : '0;

`ifdef UART_ECHO_CASE_FOLD_EN
  always_comb begin
    TxData = tx_raw;
    if (tx_raw >= WIDTH'('h61) && tx_raw <= WIDTH'('h7A))
      TxData = tx_raw - WIDTH'('h20);
  end
`else
  assign TxData = tx_raw;
`endif

endmodule

// File: doc/uart_echo_buffer.md
UART_ECHO_BUFFER -- requirements
Module: uart_echo_buffer

Interface
REQ-001 The block SHALL provide parameter DEPTH, default 8, meaning FIFO entries (power of two, 2..64).
REQ-002 The block SHALL provide parameter WIDTH, default 8, meaning bits per entry.
REQ-003 The block SHALL provide port Clock, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 The block SHALL provide port Reset, input, 1 bit, asynchronous active-low reset: assertion takes effect immediately, deassertion is sampled on Clock.
REQ-005 The block SHALL provide port RxData, input, WIDTH bits, the byte from the UART receiver (UART DataOut).
REQ-006 The block SHALL provide port RxValid, input, 1 bit, RxData valid (UART DataOutValid).
REQ-007 The block SHALL provide port RxReady, output, 1 bit, the buffer accepts a byte (drives UART DataOutReady).
REQ-008 The block SHALL provide port TxData, output, WIDTH bits, the byte to transmit (drives UART DataIn).
REQ-009 The block SHALL provide port TxValid, output, 1 bit, TxData valid (drives UART DataInValid).
REQ-010 The block SHALL provide port TxReady, input, 1 bit, the transmitter accepts (UART DataInReady).
REQ-011 The block SHALL provide port Flush, input, 1 bit, a synchronous discard of all buffered bytes.
REQ-012 The block SHALL provide port Count, output, clog2(DEPTH)+1 bits, the current occupancy.

Function
REQ-013 A push SHALL occur on a rising edge where RxValid&&RxReady; a pop SHALL occur on a rising edge where TxValid&&TxReady.
REQ-014 RxReady SHALL equal (Count!=DEPTH)&&!Flush, derived combinationally from registered state plus Flush, with no dependence on RxValid.
REQ-015 TxValid SHALL equal (Count!=0), driven from registered state only, with no combinational path from TxReady or RxValid.
REQ-016 TxData SHALL present the oldest entry, and SHALL remain stable while TxValid&&!TxReady.
REQ-017 Latency SHALL be one cycle: a byte pushed at edge N makes TxValid high after edge N; the FIFO SHALL NOT provide an empty-bypass path.
REQ-018 Simultaneous push and pop with 0<Count<DEPTH SHALL keep Count unchanged and advance both pointers.
REQ-019 When full, RxReady=0 and no push SHALL occur even if a pop occurs in the same cycle; no overwrite is permitted.
REQ-020 When empty, TxValid=0 and a pop SHALL NOT occur.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH; Count SHALL be maintained as a separate register, or equivalently as a pointer difference with an extra wrap bit.
REQ-022 Flush=1 at an edge SHALL set Count=0 and both pointers=0, and SHALL ignore any concurrent push or pop; TxValid SHALL be 0 after that edge.
REQ-023 Byte order at TxData SHALL equal arrival order at RxData with no loss or duplication.

Reset
REQ-024 While Reset=0, the block SHALL hold Count=0, pointers=0, TxValid=0, RxReady=0, and TxData=0.
REQ-025 Reset asserted mid-transfer SHALL discard all contents; after release, the first pushed byte SHALL be the first popped.
REQ-026 Storage array contents SHALL NOT require reset.

Configuration
REQ-027 With macro UART_ECHO_CASE_FOLD_EN defined, TxData SHALL map bytes 0x61-0x7A to themselves minus 0x20, and pass all other values unchanged; the mapping is combinational on the output path and adds no latency.
REQ-028 Without UART_ECHO_CASE_FOLD_EN, TxData SHALL equal the stored byte exactly.

Verification
REQ-029 Reset low for 30 cycles then high, push 0x7A with TxReady=1 -> TxValid high the cycle after the push, TxData=0x7A (0x5A with UART_ECHO_CASE_FOLD_EN), Count returns to 0.
REQ-030 TxReady=0, push 0x01..0x09 (DEPTH=8) -> Count=8, RxReady=0 after the 8th push, 0x09 not accepted; TxReady=1 -> outputs 0x01..0x08 in order.
REQ-031 Count=3, RxValid=1 and TxReady=1 for 20 cycles with an incrementing pattern -> Count stays 3, no gaps or duplicates, pointers wrap.
REQ-032 Count=5, Flush=1 with RxValid=1 at the same edge -> Count=0, TxValid=0, the concurrent byte dropped.
REQ-033 Reset pulsed low asynchronously mid-stream with Count=4 -> outputs reset immediately; the next byte 0x41 emerges first.
REQ-034 TxReady held 0 for 10 cycles with Count=2 -> TxData and TxValid stable throughout.
